// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if
//   Read port of a show-ahead fifo as seen by its consumer.
//   master : the consumer (drives fifo_rd_en, samples flag and head word)
//   slave  : the fifo (drives fifo_empty and fifo_rd_data)
//   Signals:
//     fifo_empty    fifo empty flag
//     fifo_rd_data  head word, valid whenever fifo_empty==0
//     fifo_rd_en    pop strobe, head advances on the clock edge it is high
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;

    modport master (
        output fifo_rd_en,
        input  fifo_empty,
        input  fifo_rd_data
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_empty,
        output fifo_rd_data
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   UART transmitter draining a show-ahead fifo. Pops a word whenever the fifo
//   is non-empty, tx_en is high and the line is free (idle, or in the last
//   cycle of a stop bit so frames run back-to-back), then sends it LSB-first:
//   start 0, DATA_W data bits, optional even parity bit, stop 1. Every bit is
//   held CLKS_PER_BIT clocks.
//   Build option: define FIFO_UART_TX_PARITY_EN to insert the parity bit.
//   Ports:
//     clk    clock, all state changes on posedge
//     reset  synchronous active-high reset; aborts a frame in flight
//     tx_en  1 = may start new frames, 0 = finish current frame only
//     fifo   fifo read port (master side): pop strobe is combinational
//     tx     registered serial line, idles high
//     busy   registered, high from the pop edge to the end of the stop bit
//
//   state    | meaning
//   ---------+----------------------------------------------
//   S_IDLE   | line idle, waiting for a word and tx_en
//   S_START  | driving the start bit (0)
//   S_DATA   | shifting out data bits LSB-first
//   S_PARITY | driving even parity of the captured word
//   S_STOP   | driving the stop bit (1); may pop the next word
module fifo_uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tx_en,
    fifo_uart_tx_if.master fifo,
    output logic           tx,
    output logic           busy
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic              tx_nxt, busy_nxt;
    logic              bit_end, last_data, pop;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par, par_nxt;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            tx       <= tx_nxt;
            busy     <= busy_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
            par      <= par_nxt;
`endif
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        if (pop) begin
            state_nxt = S_START;
        end else if (bit_end) begin
            case (state)
                S_START:  state_nxt = S_DATA;
                S_DATA: begin
                    if (last_data) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   state_nxt = S_IDLE;
                default:  state_nxt = state;
            endcase
        end
    end

    // Outputs and datapath next values
    always_comb begin
        bit_end   = (state != S_IDLE) && (baud_cnt == BAUD_LAST);
        last_data = (bit_cnt == BIT_LAST);
        // A pop in the last stop cycle chains frames without an idle gap.
        pop = tx_en && !fifo.fifo_empty && !reset &&
              ((state == S_IDLE) || ((state == S_STOP) && bit_end));
        fifo.fifo_rd_en = pop;

        baud_cnt_nxt = (state == S_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        tx_nxt       = tx;
        busy_nxt     = busy;
`ifdef FIFO_UART_TX_PARITY_EN
        par_nxt      = par;
`endif

        if (pop) begin
            shift_nxt    = fifo.fifo_rd_data;
            tx_nxt       = 1'b0;
            busy_nxt     = 1'b1;
            baud_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            // Data is shifted out destructively, so parity is taken at capture.
            par_nxt      = ^fifo.fifo_rd_data;
`endif
        end else if (bit_end) begin
            case (state)
                S_START: tx_nxt = shift[0];
                S_DATA: begin
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (last_data) begin
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_nxt = par;
`else
                        tx_nxt = 1'b1;
`endif
                    end else begin
                        tx_nxt = shift_nxt[0];
                    end
                end
                S_PARITY: tx_nxt = 1'b1;
                S_STOP: begin
                    tx_nxt   = 1'b1;
                    busy_nxt = 1'b0;
                end
                default: tx_nxt = 1'b1;
            endcase
        end
    end
endmodule
